// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated baud-tick generator and a small transmit FIFO.
// Words are framed LSB-first and sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLK_HZ    = 10_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4,
  parameter int LW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  output logic [LW-1:0]        fifoLevel,
  output logic                 txBusy,
  output logic                 uTx
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR_BIT,
    STOP
  } state_t;

  state_t               state, stateNext;
  logic [CW-1:0]        bitCnt, bitCntNext;
  logic [IW-1:0]        bitIdx, bitIdxNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic                 parityBit, parityNext;
  logic                 uTxNext;
  logic                 bitEnd;
  logic                 push;
  logic                 pop;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wrPtr, rdPtr;
  logic [DATA_BITS-1:0] head;

  assign txReady = (fifoLevel != LEVEL_FULL);
  assign txBusy  = (state != IDLE) || (fifoLevel != '0);
  assign push    = txValid && txReady;
  assign head    = mem[rdPtr];
  assign bitEnd  = (bitCnt == BIT_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    stateNext  = state;
    bitCntNext = bitEnd ? '0 : bitCnt + 1'b1;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    parityNext = parityBit;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        bitCntNext = '0;
        if (fifoLevel != '0) begin
          pop       = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shiftNext = shiftReg >> 1;
          if (bitIdx == DATA_LAST) begin
            stateNext  = (PARITY != 0) ? PAR_BIT : STOP;
            bitIdxNext = '0;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end
      end
      PAR_BIT: begin
        if (bitEnd) begin
          stateNext  = STOP;
          bitIdxNext = '0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (bitIdx == STOP_LAST) begin
            // Chain straight into the next start bit when more words are queued.
            if (fifoLevel != '0) begin
              pop       = 1'b1;
              stateNext = START;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (pop) begin
      shiftNext  = head;
      parityNext = (PARITY == 1) ? ~^head : ^head;
    end

    // The line level is derived from the next state so uTx comes straight from a flop.
    case (stateNext)
      START:   uTxNext = 1'b0;
      DATA:    uTxNext = shiftNext[0];
      PAR_BIT: uTxNext = parityNext;
      default: uTxNext = 1'b1;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its sources.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state     <= IDLE;
      bitCnt    <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      uTx       <= 1'b1;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      parityBit <= parityNext;
      uTx       <= uTxNext;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoLevel <= fifoLevel + 1'b1;
        2'b01:   fifoLevel <= fifoLevel - 1'b1;
        default: fifoLevel <= fifoLevel;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= txData;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five configurations share one clock, and a per-instance line
// monitor decodes frames clock-by-clock against a scoreboard filled at each accepted push.
module tb_uart_tx_fifo;

  localparam int NI = 5;
  localparam int DIVS [NI] = '{87, 10, 10, 10, 5208};
  localparam int DBS  [NI] = '{8, 5, 8, 8, 8};
  localparam int PARS [NI] = '{0, 0, 1, 2, 0};
  localparam int STBS [NI] = '{1, 2, 1, 1, 1};
  localparam int DEPS [NI] = '{4, 4, 4, 2, 4};

  logic          clk;
  logic [NI-1:0] nRst;
  logic [NI-1:0] txValid;
  wire  [NI-1:0] txReady;
  wire  [NI-1:0] txBusy;
  wire  [NI-1:0] uTx;
  logic [7:0]    txData0, txData2, txData3, txData4;
  logic [4:0]    txData1;
  wire  [2:0]    lvl0, lvl1, lvl2, lvl4;
  wire  [1:0]    lvl3;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbq [NI][$];

  uart_tx_fifo u0 (
    .clk(clk), .nRst(nRst[0]), .txData(txData0), .txValid(txValid[0]),
    .txReady(txReady[0]), .fifoLevel(lvl0), .txBusy(txBusy[0]), .uTx(uTx[0]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .STOP_BITS(2)) u1 (
    .clk(clk), .nRst(nRst[1]), .txData(txData1), .txValid(txValid[1]),
    .txReady(txReady[1]), .fifoLevel(lvl1), .txBusy(txBusy[1]), .uTx(uTx[1]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(1)) u2 (
    .clk(clk), .nRst(nRst[2]), .txData(txData2), .txValid(txValid[2]),
    .txReady(txReady[2]), .fifoLevel(lvl2), .txBusy(txBusy[2]), .uTx(uTx[2]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .DEPTH(2)) u3 (
    .clk(clk), .nRst(nRst[3]), .txData(txData3), .txValid(txValid[3]),
    .txReady(txReady[3]), .fifoLevel(lvl3), .txBusy(txBusy[3]), .uTx(uTx[3]));

  uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(9600)) u4 (
    .clk(clk), .nRst(nRst[4]), .txData(txData4), .txValid(txValid[4]),
    .txReady(txReady[4]), .fifoLevel(lvl4), .txBusy(txBusy[4]), .uTx(uTx[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setData(input int id, input logic [7:0] w);
    case (id)
      0:       txData0 = w;
      1:       txData1 = w[4:0];
      2:       txData2 = w;
      3:       txData3 = w;
      default: txData4 = w;
    endcase
  endtask

  // Offers one word and holds it until accepted; returns just after the accept edge.
  task automatic pushWord(input int id, input logic [7:0] w);
    logic rdy;
    int   n;
    setData(id, w);
    txValid[id] = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (rdy !== 1'b1 && n < 60000) begin
      @(negedge clk);
      rdy = txReady[id];
      @(posedge clk);
      #1;
      n++;
    end
    txValid[id] = 1'b0;
    if (rdy === 1'b1) sbq[id].push_back(w);
    else check($sformatf("u%0d_accept", id), rdy, 1);
  endtask

  // Counts edges from now until txBusy drops.
  task automatic busyLen(input int id, input int limit, output int n);
    n = 0;
    while (txBusy[id] === 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Decodes each frame on uTx[id], checking every bit holds for exactly DIV clocks.
  task automatic monitor(input int id);
    int         div, db, par, stb, nbits, bound, n, ok;
    logic [7:0] w;
    logic [11:0] bits;
    logic       p, aborted;
    div = DIVS[id];
    db  = DBS[id];
    par = PARS[id];
    stb = STBS[id];
    bound = (DEPS[id] + 2) * (1 + db + ((par != 0) ? 1 : 0) + stb) * div;
    n = 0;
    @(negedge clk);
    forever begin
      if (sbq[id].size() == 0) begin
        n = 0;
        if (nRst[id] === 1'b1 && uTx[id] === 1'b0)
          check($sformatf("u%0d_idle_line", id), uTx[id], 1);
        @(negedge clk);
      end else if (uTx[id] !== 1'b0) begin
        n++;
        if (n > bound) begin
          check($sformatf("u%0d_start_seen", id), uTx[id], 0);
          void'(sbq[id].pop_front());
          n = 0;
        end
        @(negedge clk);
      end else begin
        n = 0;
        w = sbq[id].pop_front();
        bits = '0;
        p = 1'b0;
        for (int i = 0; i < db; i++) begin
          bits[1 + i] = w[i];
          p = p ^ w[i];
        end
        nbits = 1 + db;
        if (par != 0) begin
          bits[nbits] = (par == 1) ? ~p : p;
          nbits++;
        end
        for (int s = 0; s < stb; s++) begin
          bits[nbits] = 1'b1;
          nbits++;
        end
        aborted = 1'b0;
        for (int b = 0; b < nbits; b++) begin
          ok = 0;
          for (int c = 0; c < div; c++) begin
            if (nRst[id] !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (uTx[id] === bits[b]) ok++;
            @(negedge clk);
          end
          if (aborted) break;
          check($sformatf("u%0d_w%02h_bit%0d", id, w, b), ok, div);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);
  initial monitor(4);

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n, idx, accepted, early, accAtFull, lvlAtFull, lastEdge, lows;
    logic       rdy;
    logic [7:0] d;

    txValid = '0;
    nRst    = '0;
    txData0 = '0;
    txData1 = '0;
    txData2 = '0;
    txData3 = '0;
    txData4 = '0;
    repeat (3) @(posedge clk);
    #1;
    nRst = '1;

    // Reset state
    @(negedge clk);
    check("rst_uTx_all", uTx, 5'h1F);
    check("rst_txReady", txReady[0], 1);
    check("rst_fifoLevel", lvl0, 0);
    check("rst_txBusy", txBusy[0], 0);
    @(posedge clk);
    #1;

    // Single 8N1 word from idle: latency and frame length
    pushWord(0, 8'h08);
    check("lat_level_after_accept", lvl0, 1);
    check("lat_line_after_accept", uTx[0], 1);
    check("lat_busy_after_accept", txBusy[0], 1);
    @(posedge clk);
    #1;
    check("lat_line_after_pop", uTx[0], 0);
    check("lat_level_after_pop", lvl0, 0);
    busyLen(0, 2000, n);
    check("busy_len_8n1", n, 870);

    // Five data bits with two stop bits, then odd and even parity
    pushWord(1, 8'h1F);
    busyLen(1, 2000, n);
    check("busy_len_5n2", n, (1 + 5 + 2) * 10 + 1);
    pushWord(1, 8'h0A);
    pushWord(2, 8'h08);
    pushWord(2, 8'h00);
    pushWord(2, 8'hFF);
    pushWord(3, 8'h08);
    pushWord(3, 8'h00);
    pushWord(3, 8'h81);
    check("depth2_level_full", lvl3, 2);
    check("depth2_ready_low", txReady[3], 0);
    n = 0;
    while (txBusy[3:1] !== 3'b000 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("small_div_idle", txBusy[3:1], 0);

    // Held txValid with incrementing data: fill, back-pressure, gapless frames
    d = 8'h01;
    setData(0, d);
    txValid[0] = 1'b1;
    idx = 0;
    accepted = 0;
    early = 0;
    accAtFull = -1;
    lvlAtFull = 0;
    while (accepted < 8 && idx < 20000) begin
      @(negedge clk);
      rdy = txReady[0];
      if (rdy !== 1'b1 && accAtFull < 0) begin
        accAtFull = accepted;
        lvlAtFull = int'(lvl0);
      end
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        sbq[0].push_back(d);
        accepted++;
        if (idx <= 871) early++;
        d++;
        setData(0, d);
      end
      idx++;
    end
    txValid[0] = 1'b0;
    check("b2b_accepted", accepted, 8);
    check("b2b_accepted_at_full", accAtFull, 5);
    check("b2b_level_at_full", lvlAtFull, 4);
    check("b2b_accepted_first_frame", early, 5);
    lastEdge = idx - 1;
    while (txBusy[0] === 1'b1 && idx < 20000) begin
      @(posedge clk);
      #1;
      lastEdge = idx;
      idx++;
    end
    check("b2b_busy_end_edge", lastEdge, 1 + 8 * 870);

    // Reset during data bit 3 with two words queued
    pushWord(0, 8'h55);
    pushWord(0, 8'hA3);
    pushWord(0, 8'h3C);
    repeat (387) @(posedge clk);
    #1;
    check("midrst_pre_level", lvl0, 2);
    check("midrst_pre_line", uTx[0], 0);
    nRst[0] = 1'b0;
    sbq[0].delete();
    @(posedge clk);
    #1;
    nRst[0] = 1'b1;
    check("midrst_line", uTx[0], 1);
    check("midrst_level", lvl0, 0);
    check("midrst_ready", txReady[0], 1);
    check("midrst_busy", txBusy[0], 0);
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (uTx[0] !== 1'b1) lows++;
    end
    check("midrst_line_quiet", lows, 0);
    @(posedge clk);
    #1;

    // 50 MHz / 9600 baud: DIV = 5208
    pushWord(4, 8'hC5);
    busyLen(4, 60000, n);
    check("busy_len_div5208", n, 52080 + 1);

    // Everything drained and every expected frame observed
    repeat (4) @(negedge clk);
    check("end_busy_all", txBusy, 0);
    check("end_level0", lvl0, 0);
    check("end_level1", lvl1, 0);
    check("end_level2", lvl2, 0);
    check("end_level3", lvl3, 0);
    check("end_level4", lvl4, 0);
    for (int i = 0; i < NI; i++)
      check($sformatf("end_scoreboard_u%0d", i), sbq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
